// File: rtl/soc_periph_arbiter.sv
// -----------------------------------------------------------------------------
// soc_periph_arbiter
//   Shares the SoC peripheral bus between NrMasters requesters. A round-robin
//   arbiter grants one master at a time. The address is decoded against the
//   fixed SoC map, and exactly one transaction is outstanding at any moment.
//   Unmapped or disabled regions get an immediate decode-error response and
//   never reach the peripheral bus.
//
//   Region index (one-hot slv_sel_o bit):
//     0 DRAM, 1 GPIO, 2 Eth, 3 SPI, 4 Timer, 5 UART, 6 PLIC, 7 CLINT, 8 ROM, 9 Debug
//
//   Optional feature macro: SOC_ARB_TIMEOUT_EN
//     When defined, a transaction that waits TimeoutCycles-1 cycles in REQ/WAIT
//     without a peripheral response is completed with err=1 and rdata=0.
//     When undefined, REQ/WAIT wait indefinitely.
//
// Ports
//   clk_i, rst_i            clock (rising edge), async active-high reset
//   mst_req_i/addr/we/wdata/be   per-master request, held until mst_gnt_o
//   mst_gnt_o               one-cycle grant pulse (request captured)
//   mst_rvalid_o            one-cycle response pulse to the granted master
//   mst_rdata_o, mst_err_o  shared response data/error, qualified by rvalid
//   slv_req_o, slv_sel_o    peripheral request and one-hot region select
//   slv_addr/we/wdata/be_o  captured request fields
//   slv_gnt_i               peripheral accepted the request
//   slv_rvalid_i/rdata/err  peripheral response
// -----------------------------------------------------------------------------
module soc_periph_arbiter #(
   parameter int unsigned         NrMasters     = 2,
   parameter int unsigned         NbPeriph      = 10,
   parameter logic [NbPeriph-1:0] RegionEn      = {NbPeriph{1'b1}},
   parameter int unsigned         TimeoutCycles = 1024
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NrMasters-1:0]       mst_req_i,
   input  logic [NrMasters-1:0][63:0] mst_addr_i,
   input  logic [NrMasters-1:0]       mst_we_i,
   input  logic [NrMasters-1:0][63:0] mst_wdata_i,
   input  logic [NrMasters-1:0][7:0]  mst_be_i,
   output logic [NrMasters-1:0]       mst_gnt_o,
   output logic [NrMasters-1:0]       mst_rvalid_o,
   output logic [63:0]                mst_rdata_o,
   output logic                       mst_err_o,
   output logic                       slv_req_o,
   output logic [NbPeriph-1:0]        slv_sel_o,
   output logic [63:0]                slv_addr_o,
   output logic                       slv_we_o,
   output logic [63:0]                slv_wdata_o,
   output logic [7:0]                 slv_be_o,
   input  logic                       slv_gnt_i,
   input  logic                       slv_rvalid_i,
   input  logic [63:0]                slv_rdata_i,
   input  logic                       slv_err_i
);

   localparam int unsigned MW    = (NrMasters > 1) ? $clog2(NrMasters) : 1;
   localparam int unsigned NrMap = (NbPeriph < 10) ? NbPeriph : 10;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_RSP  = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd4;

   localparam logic [63:0] RegionBase [10] = '{
      64'h0000_0000_8000_0000, 64'h0000_0000_4000_0000, 64'h0000_0000_3000_0000,
      64'h0000_0000_2000_0000, 64'h0000_0000_1800_0000, 64'h0000_0000_1000_0000,
      64'h0000_0000_0C00_0000, 64'h0000_0000_0200_0000, 64'h0000_0000_0001_0000,
      64'h0000_0000_0000_0000};
   localparam logic [63:0] RegionLen [10] = '{
      64'h0000_0000_4000_0000, 64'h0000_0000_0000_1000, 64'h0000_0000_0001_0000,
      64'h0000_0000_0080_0000, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_1000,
      64'h0000_0000_03FF_FFFF, 64'h0000_0000_000C_0000, 64'h0000_0000_0001_0000,
      64'h0000_0000_0000_1000};

   // Map lookup; regions do not overlap, so at most one bit is set.
   function automatic logic [NbPeriph-1:0] decode(input logic [63:0] a);
      logic [NbPeriph-1:0] hit;
      hit = '0;
      for (int r = 0; r < NrMap; r++) begin
         hit[r] = (a >= RegionBase[r]) && (a < (RegionBase[r] + RegionLen[r]));
      end
      return hit & RegionEn;
   endfunction

   logic [2:0]          state_r;
   logic [MW-1:0]       last_r;
   logic [MW-1:0]       win_r;
   logic [63:0]         addr_r;
   logic                we_r;
   logic [63:0]         wdata_r;
   logic [7:0]          be_r;
   logic [NbPeriph-1:0] sel_r;
   logic [63:0]         rdata_r;
   logic                err_r;

   logic [MW-1:0]       win_s;
   logic [MW-1:0]       idx_s;
   logic                any_s;
   logic [NbPeriph-1:0] dec_s;
   logic [NrMasters-1:0] gnt_s;
   logic                timeout_s;

`ifdef SOC_ARB_TIMEOUT_EN
   logic [31:0]         cnt_r;
   assign timeout_s = (cnt_r == 32'(TimeoutCycles - 1));
`else
   assign timeout_s = 1'b0;
`endif

   // Round-robin winner search starting one past the last granted master.
   always_comb begin
      win_s = '0;
      idx_s = '0;
      any_s = 1'b0;
      for (int i = 0; i < NrMasters; i++) begin
         idx_s = MW'((int'(last_r) + 1 + i) % int'(NrMasters));
         if (mst_req_i[idx_s] && !any_s) begin
            win_s = idx_s;
            any_s = 1'b1;
         end else begin
            any_s = any_s;
         end
      end
   end

   assign dec_s = decode(mst_addr_i[win_s]);

   // Grant pulse only in IDLE; suppressed while reset is held so nothing is
   // granted that the state register cannot capture.
   always_comb begin
      gnt_s = '0;
      if ((state_r == ST_IDLE) && any_s && !rst_i) begin
         gnt_s[win_s] = 1'b1;
      end else begin
         gnt_s = '0;
      end
   end

   // Transaction FSM and capture registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= ST_IDLE;
         last_r  <= MW'(NrMasters - 1);
         win_r   <= '0;
         addr_r  <= 64'd0;
         we_r    <= 1'b0;
         wdata_r <= 64'd0;
         be_r    <= 8'd0;
         sel_r   <= '0;
         rdata_r <= 64'd0;
         err_r   <= 1'b0;
`ifdef SOC_ARB_TIMEOUT_EN
         cnt_r   <= 32'd0;
`endif
      end else begin
`ifdef SOC_ARB_TIMEOUT_EN
         if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
            cnt_r <= cnt_r + 32'd1;
         end else begin
            cnt_r <= 32'd0;
         end
`endif
         case (state_r)
            ST_IDLE: begin
               if (any_s) begin
                  win_r   <= win_s;
                  last_r  <= win_s;
                  addr_r  <= mst_addr_i[win_s];
                  we_r    <= mst_we_i[win_s];
                  wdata_r <= mst_wdata_i[win_s];
                  be_r    <= mst_be_i[win_s];
                  sel_r   <= dec_s;
                  rdata_r <= 64'd0;
                  err_r   <= 1'b0;
                  state_r <= (dec_s == '0) ? ST_ERR : ST_REQ;
               end
            end
            ST_REQ: begin
               if (slv_gnt_i && slv_rvalid_i) begin
                  rdata_r <= slv_rdata_i;
                  err_r   <= slv_err_i;
                  state_r <= ST_RSP;
               end else if (timeout_s) begin
                  rdata_r <= 64'd0;
                  err_r   <= 1'b1;
                  state_r <= ST_RSP;
               end else if (slv_gnt_i) begin
                  state_r <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (slv_rvalid_i) begin
                  rdata_r <= slv_rdata_i;
                  err_r   <= slv_err_i;
                  state_r <= ST_RSP;
               end else if (timeout_s) begin
                  rdata_r <= 64'd0;
                  err_r   <= 1'b1;
                  state_r <= ST_RSP;
               end
            end
            ST_RSP:  state_r <= ST_IDLE;
            ST_ERR:  state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Response and peripheral-side outputs decoded from the state register.
   always_comb begin
      mst_rvalid_o = '0;
      mst_rdata_o  = 64'd0;
      mst_err_o    = 1'b0;
      slv_req_o    = 1'b0;
      slv_sel_o    = '0;
      case (state_r)
         ST_REQ: begin
            slv_req_o = 1'b1;
            slv_sel_o = sel_r;
         end
         ST_WAIT: begin
            slv_sel_o = sel_r;
         end
         ST_RSP: begin
            mst_rvalid_o[win_r] = 1'b1;
            mst_rdata_o         = rdata_r;
            mst_err_o           = err_r;
         end
         ST_ERR: begin
            mst_rvalid_o[win_r] = 1'b1;
            mst_err_o           = 1'b1;
         end
         default: begin
            slv_req_o = 1'b0;
         end
      endcase
   end

   assign mst_gnt_o   = gnt_s;
   assign slv_addr_o  = addr_r;
   assign slv_we_o    = we_r;
   assign slv_wdata_o = wdata_r;
   assign slv_be_o    = be_r;

endmodule
